// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: reset vector, NOP encoding, opcodes,
// fetch FSM states and the queue entry layout.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = {25'h0, OPC_OP_IMM};

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DROP  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, inst} pairs between instruction memory and decode.
module fetch_queue
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: storage is deliberately not reset; count decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word fetches, queues responses for decode and
// handles redirects, dropping a response that was already in flight.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  localparam logic [1:0] QFULL = QDEPTH[1:0];

  fetch_state_t state, state_next;
  logic [31:0]  fetch_pc, fetch_pc_next;
  logic [31:0]  drop_addr, drop_addr_next;
  logic [31:0]  last_pc;
  logic         push, pop;
  logic [1:0]   count;
  fetch_entry_t head;

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_next     = state;
    fetch_pc_next  = fetch_pc;
    drop_addr_next = drop_addr;
    push           = 1'b0;
    imem_req       = 1'b0;
    imem_addr      = fetch_pc;
    case (state)
      ST_FETCH: begin
        // Request depends only on registered count, never on id_ready.
        imem_req = (count < QFULL);
        if (redirect_valid) begin
          fetch_pc_next = align_pc(redirect_pc);
          if (imem_req && !imem_ack) begin
            state_next     = ST_DROP;
            drop_addr_next = fetch_pc;
          end
        end else if (imem_req && imem_ack) begin
          push          = 1'b1;
          fetch_pc_next = fetch_pc + 32'd4;
        end
      end
      ST_DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr;
        if (redirect_valid) fetch_pc_next = align_pc(redirect_pc);
        if (imem_ack)       state_next    = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase
    if (rst) imem_req = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments only; the comb block above uses blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      fetch_pc  <= RESET_PC;
      drop_addr <= RESET_PC;
      last_pc   <= 32'h0;
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      drop_addr <= drop_addr_next;
      if (id_valid) last_pc <= head.pc;
    end
  end

  assign id_valid = (count != 2'd0);
  assign pop      = id_valid && id_ready;
  assign id_inst  = id_valid ? head.inst : NOP_INST;
  assign id_pc    = id_valid ? head.pc   : last_pc;

  fetch_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_entry ('{pc: fetch_pc, inst: imem_rdata}),
    .head       (head),
    .count      (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirects,
// PC wrap-around and reset behaviour.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ack_mode;
  logic        ack_man;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;

  logic        imem_req, imem_ack, id_valid;
  logic [31:0] imem_addr, imem_rdata, id_inst, id_pc;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_inst, w_pc;

  // Memory model: each word encodes its own address.
  assign imem_ack   = ack_mode ? imem_req : ack_man;
  assign imem_rdata = imem_addr ^ 32'hCAFE_0000;
  assign w_rdata    = w_addr ^ 32'hCAFE_0000;

  int checks   = 0;
  int failures = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_ready       (id_ready)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (w_req),
    .imem_addr      (w_addr),
    .imem_ack       (w_req),
    .imem_rdata     (w_rdata),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .id_valid       (w_valid),
    .id_inst        (w_inst),
    .id_pc          (w_pc),
    .id_ready       (1'b1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; ack_mode = 1'b1; ack_man = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;

    // Reset state
    next_cycle(); next_cycle();
    #1;
    check("rst_req",   {31'h0, imem_req}, 32'd0);
    check("rst_valid", {31'h0, id_valid}, 32'd0);
    check("rst_inst",  id_inst, NOP_INST);
    check("rst_pc",    id_pc, 32'h0);

    // Zero-wait streaming, plus wrap-around on the second instance
    rst = 1'b0;
    #1;
    check("first_req",  {31'h0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    check("first_valid", {31'h0, id_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      #1;
      check("stream_valid", {31'h0, id_valid}, 32'd1);
      check("stream_pc", id_pc, 32'(4 * i));
      check("stream_inst", id_inst, 32'(4 * i) ^ 32'hCAFE_0000);
      if (i < 3) check("wrap_pc", w_pc, 32'hFFFF_FFF8 + 32'(4 * i));
    end

    // Back-pressure: queue fills with pc 0 and 4, then request stops
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; id_ready = 1'b0;
    repeat (5) next_cycle();
    #1;
    check("full_valid", {31'h0, id_valid}, 32'd1);
    check("full_pc",    id_pc, 32'h0);
    check("full_req",   {31'h0, imem_req}, 32'd0);
    check("full_addr",  imem_addr, 32'h8);
    id_ready = 1'b1;
    next_cycle();
    id_ready = 1'b0;
    #1;
    check("drain_pc",   id_pc, 32'h4);
    check("drain_inst", id_inst, 32'h4 ^ 32'hCAFE_0000);
    check("drain_req",  {31'h0, imem_req}, 32'd1);
    check("drain_addr", imem_addr, 32'h8);

    // Slow memory, redirect while request outstanding
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; ack_mode = 1'b0; ack_man = 1'b0; id_ready = 1'b1;
    #1;
    check("slow_req0", {31'h0, imem_req}, 32'd1);
    next_cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0101;
    next_cycle();
    redirect_valid = 1'b0; ack_man = 1'b1;
    #1;
    check("drop_req",  {31'h0, imem_req}, 32'd1);
    check("drop_addr", imem_addr, 32'h0);
    next_cycle();
    #1;
    check("drop_discard", {31'h0, id_valid}, 32'd0);
    check("redir_addr",   imem_addr, 32'h0000_0100);
    check("redir_req",    {31'h0, imem_req}, 32'd1);
    next_cycle();
    // Ack of 0x104 coincides with redirect and with a decode transfer
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    check("redir_id_valid", {31'h0, id_valid}, 32'd1);
    check("redir_id_pc",    id_pc, 32'h0000_0100);
    check("redir_id_inst",  id_inst, 32'hCAFE_0100);
    next_cycle();
    ack_man = 1'b0; redirect_pc = 32'h0000_0300;
    #1;
    check("coinc_valid", {31'h0, id_valid}, 32'd0);
    check("coinc_inst",  id_inst, NOP_INST);
    check("hold_pc",     id_pc, 32'h0000_0100);
    check("coinc_addr",  imem_addr, 32'h0000_0200);

    // Redirect again while dropping: newest target wins
    next_cycle();
    redirect_pc = 32'h0000_0406;
    #1;
    check("drop2_addr", imem_addr, 32'h0000_0200);
    next_cycle();
    redirect_valid = 1'b0; ack_man = 1'b1;
    #1;
    check("drop2_req", {31'h0, imem_req}, 32'd1);
    check("drop2_hold", imem_addr, 32'h0000_0200);
    next_cycle();
    #1;
    check("newest_addr",  imem_addr, 32'h0000_0404);
    check("newest_empty", {31'h0, id_valid}, 32'd0);
    next_cycle();
    ack_man = 1'b0;
    #1;
    check("newest_pc",   id_pc, 32'h0000_0404);
    check("newest_inst", id_inst, 32'hCAFE_0404);

    // Reset with a full queue, ack during reset ignored
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; ack_mode = 1'b1; id_ready = 1'b0;
    next_cycle(); next_cycle();
    #1;
    check("prefill_valid", {31'h0, id_valid}, 32'd1);
    check("prefill_req",   {31'h0, imem_req}, 32'd0);
    rst = 1'b1; ack_mode = 1'b0; ack_man = 1'b1;
    next_cycle();
    #1;
    check("rst2_valid", {31'h0, id_valid}, 32'd0);
    check("rst2_inst",  id_inst, NOP_INST);
    check("rst2_req",   {31'h0, imem_req}, 32'd0);
    check("rst2_pc",    id_pc, 32'h0);
    rst = 1'b0; ack_man = 1'b0;
    #1;
    check("rel_req",   {31'h0, imem_req}, 32'd1);
    check("rel_addr",  imem_addr, 32'h0);
    next_cycle();
    #1;
    check("rel_valid", {31'h0, id_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
